// File: rtl/awgn_burst_if.sv
// Handshake and coefficient-table bundle for the AWGN burst controller.
// The slave side is the controller; the master side is its environment.
interface awgn_burst_if #(
  parameter int RND_W = 64,
  parameter int OUT_W = 16,
  parameter int SEG_W = 7,
  parameter int CNT_W = 8
);
  logic             go;
  logic             abort;
  logic [CNT_W-1:0] burst_len;
  logic             rnd_valid;
  logic [RND_W-1:0] rnd;
  logic             rnd_ready;
  logic [SEG_W-1:0] rom_addr;
  logic [OUT_W-1:0] rom_c0;
  logic [OUT_W-1:0] rom_c1;
  logic             awgn_valid;
  logic             awgn_ready;
  logic [OUT_W-1:0] awgn_out;
  logic             busy;
  logic             done;

  modport master (
    output go, abort, burst_len,
    output rnd_valid, rnd,
    output rom_c0, rom_c1,
    output awgn_ready,
    input  rnd_ready, rom_addr,
    input  awgn_valid, awgn_out,
    input  busy, done
  );

  modport slave (
    input  go, abort, burst_len,
    input  rnd_valid, rnd,
    input  rom_c0, rom_c1,
    input  awgn_ready,
    output rnd_ready, rom_addr,
    output awgn_valid, awgn_out,
    output busy, done
  );
endinterface

// File: rtl/awgn_burst_ctrl.sv
// Burst controller turning uniform random words into Gaussian samples
// via leading-zero segment lookup and piecewise-linear interpolation.
module awgn_burst_ctrl #(
  parameter int RND_W  = 64,
  parameter int OUT_W  = 16,
  parameter int MASK_W = 15,
  parameter int SEG_W  = 7,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  awgn_burst_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LZD,
    LOOKUP,
    MAC,
    OUT,
    DONE
  } state_t;

  localparam int HW   = RND_W - 3;
  localparam int PW   = OUT_W + MASK_W + 1;
  localparam int YW   = PW + 2;
  localparam int MAXV = 2 ** (OUT_W - 1) - 1;
  localparam logic signed [YW-1:0] SMAX = YW'(MAXV);
  localparam logic signed [YW-1:0] SMIN = -SMAX;

  state_t state;
  state_t nxt;

  logic                     kill;
  logic                     rdy;
  logic                     vld;
  logic                     dn;
  logic [CNT_W-1:0]         remaining;
  logic [HW-1:0]            mant;
  logic                     sgn;
  logic signed [OUT_W-1:0]  c0_q;
  logic signed [OUT_W-1:0]  c1_q;
  logic [SEG_W-1:0]         seg;
  logic [SEG_W-1:0]         addr_q;
  logic [OUT_W-1:0]         out_q;
  logic [MASK_W-1:0]        frac;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     prod_sh;
  logic signed [YW-1:0]     sum;
  logic signed [YW-1:0]     res;
  logic [OUT_W-1:0]         sat;

  assign bus.rnd_ready  = rdy;
  assign bus.awgn_valid = vld;
  assign bus.done       = dn;
  assign bus.busy       = (state != IDLE);
  assign bus.rom_addr   = addr_q;
  assign bus.awgn_out   = out_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state and handshake outputs; abort overrides every transition
  always_comb begin
    nxt  = state;
    rdy  = 1'b0;
    vld  = 1'b0;
    dn   = 1'b0;
    kill = bus.abort && (state != IDLE);
    if (kill) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go && (bus.burst_len != '0)) begin
            nxt = FETCH;
          end
        end
        FETCH: begin
          rdy = 1'b1;
          if (bus.rnd_valid) begin
            nxt = LZD;
          end
        end
        LZD:    nxt = LOOKUP;
        LOOKUP: nxt = MAC;
        MAC:    nxt = OUT;
        OUT: begin
          vld = 1'b1;
          if (bus.awgn_ready) begin
            if (remaining == CNT_W'(1)) begin
              nxt = DONE;
            end else begin
              nxt = FETCH;
            end
          end
        end
        DONE: begin
          dn  = 1'b1;
          nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Segment index: leading zeros above the sign/unused bits
  always_comb begin
    seg = SEG_W'(HW);
    for (int i = 0; i < HW; i++) begin
      if (mant[i]) begin
        seg = SEG_W'(HW - 1 - i);
      end
    end
  end

  // Interpolate, apply sign, saturate symmetrically
  always_comb begin
    frac    = mant[MASK_W-1:0];
    prod    = PW'(c1_q) * PW'($signed({1'b0, frac}));
    prod_sh = prod >>> MASK_W;
    sum     = YW'(c0_q) + YW'(prod_sh);
    res     = sgn ? -sum : sum;
    if (res > SMAX) begin
      sat = SMAX[OUT_W-1:0];
    end else if (res < SMIN) begin
      sat = SMIN[OUT_W-1:0];
    end else begin
      sat = res[OUT_W-1:0];
    end
  end

  // Datapath registers advanced by the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      mant      <= '0;
      sgn       <= 1'b0;
      addr_q    <= '0;
      c0_q      <= '0;
      c1_q      <= '0;
      out_q     <= '0;
    end else if (!kill) begin
      case (state)
        IDLE: begin
          if (bus.go && (bus.burst_len != '0)) begin
            remaining <= bus.burst_len;
          end
        end
        FETCH: begin
          if (bus.rnd_valid) begin
            mant <= bus.rnd[RND_W-1:3];
            sgn  <= bus.rnd[0];
          end
        end
        LZD: begin
          addr_q <= seg;
        end
        LOOKUP: begin
          c0_q <= $signed(bus.rom_c0);
          c1_q <= $signed(bus.rom_c1);
        end
        MAC: begin
          out_q <= sat;
        end
        OUT: begin
          if (bus.awgn_ready) begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_awgn_burst_ctrl.sv
// Directed bench for awgn_burst_ctrl with a behavioural sample model
// and a per-cycle output compare.
module tb_awgn_burst_ctrl;
  localparam int RND_W  = 64;
  localparam int OUT_W  = 16;
  localparam int MASK_W = 15;
  localparam int SEG_W  = 7;
  localparam int CNT_W  = 8;

  logic clk;
  logic rst;

  awgn_burst_if #(
    .RND_W(RND_W), .OUT_W(OUT_W), .SEG_W(SEG_W), .CNT_W(CNT_W)
  ) bus ();

  awgn_burst_ctrl #(
    .RND_W(RND_W), .OUT_W(OUT_W), .MASK_W(MASK_W),
    .SEG_W(SEG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int c0_base = 0;
  int c1_base = 0;
  int cyc = 0;
  int cap_cnt = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int stall_n = 0;
  int stall_ctr = 0;
  int last_hs = -1;
  bit tp_chk = 0;
  bit prev_done = 0;

  logic [63:0] src_q[$];
  logic [22:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // table: c0 = base + segment, c1 = base
  always_comb begin
    bus.rom_c0 = 16'(c0_base + int'(bus.rom_addr));
    bus.rom_c1 = 16'(c1_base);
  end

  function automatic logic [22:0] model(input logic [63:0] r);
    int seg;
    longint c0;
    longint c1;
    longint x;
    longint y;
    logic [15:0] c0w;
    logic [15:0] c1w;
    seg = 61;
    for (int i = 63; i >= 3; i--) begin
      if (r[i]) begin
        seg = 63 - i;
        break;
      end
    end
    c0w = 16'(c0_base + seg);
    c1w = 16'(c1_base);
    c0 = longint'($signed(c0w));
    c1 = longint'($signed(c1w));
    x = longint'(r[17:3]);
    y = c0 + ((c1 * x) >>> 15);
    if (r[0]) y = -y;
    if (y > 32767) y = 32767;
    if (y < -32767) y = -32767;
    return {7'(seg), 16'(y)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // handshake accounting and throughput
  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.rnd_valid && bus.rnd_ready) begin
      exp_q.push_back(model(bus.rnd));
      void'(src_q.pop_front());
      cap_cnt++;
    end
    if (!rst && bus.awgn_valid && bus.awgn_ready) begin
      hs_cnt++;
      stall_ctr = 0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (tp_chk && last_hs >= 0) chk("throughput", cyc - last_hs, 5);
      last_hs = cyc;
    end
  end

  // compare outputs, then drive stream inputs
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.awgn_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_sample: got %0h want none", bus.awgn_out);
        end else begin
          chk("awgn_out", bus.awgn_out, exp_q[0][15:0]);
          chk("rom_addr", bus.rom_addr, exp_q[0][22:16]);
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_no_valid", bus.awgn_valid, 0);
        chk("done_single", prev_done, 0);
      end
      if (bus.rnd_ready) chk("ready_busy", bus.busy, 1);
    end
    prev_done = bus.done;
    bus.rnd_valid = (src_q.size() != 0);
    bus.rnd = (src_q.size() != 0) ? src_q[0] : 64'h0;
    if (bus.awgn_valid && stall_ctr < stall_n) begin
      bus.awgn_ready = 1'b0;
      stall_ctr++;
    end else begin
      bus.awgn_ready = 1'b1;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic go_pulse(input int len);
    bus.burst_len = CNT_W'(len);
    bus.go = 1'b1;
    tick;
    bus.go = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      tick;
      n++;
    end
    chk("idle_timeout", bus.busy, 0);
  endtask

  task automatic wait_cap(input int target);
    int n;
    n = 0;
    while (cap_cnt < target && n < 200) begin
      tick;
      n++;
    end
    chk("cap_timeout", cap_cnt >= target, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_valid"}, bus.awgn_valid, 0);
    chk({tag, "_rnd_ready"}, bus.rnd_ready, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rom_addr"}, bus.rom_addr, 0);
    chk({tag, "_out"}, bus.awgn_out, 0);
  endtask

  task automatic single(input int c0b, input int c1b,
                        input logic [63:0] w, input logic [15:0] want,
                        input logic [6:0] seg);
    int d0;
    int h0;
    d0 = done_cnt;
    h0 = hs_cnt;
    c0_base = c0b;
    c1_base = c1b;
    chk("model_pin", model(w), {seg, want});
    src_q.push_back(w);
    go_pulse(1);
    wait_idle;
    tick;
    chk("lit_out", bus.awgn_out, want);
    chk("lit_seg", bus.rom_addr, seg);
    chk("lit_done", done_cnt - d0, 1);
    chk("lit_hs", hs_cnt - h0, 1);
  endtask

  initial begin
    int d0;
    int h0;
    int t;
    rst = 1'b1;
    bus.go = 1'b1;
    bus.abort = 1'b1;
    bus.burst_len = 8'd5;
    repeat (3) tick;
    check_zero("reset");
    bus.go = 1'b0;
    bus.abort = 1'b0;
    tick;
    rst = 1'b0;
    tick;

    single(100, 200, 64'h8000_0000_0002_0000, 16'h00C8, 7'h00);
    single(100, 200, 64'h8000_0000_0002_0001, 16'hFF38, 7'h00);
    single(100, 200, 64'h0000_0000_0000_0001, 16'hFF5F, 7'h3D);
    single(32767, 32767, 64'h8000_0000_0003_FFF8, 16'h7FFF, 7'h00);
    single(32767, 32767, 64'h8000_0000_0003_FFF9, 16'h8001, 7'h00);

    // three samples, each stalled four cycles
    c0_base = -300;
    c1_base = 1000;
    d0 = done_cnt;
    h0 = hs_cnt;
    stall_n = 4;
    src_q.push_back(64'h0123_4567_89AB_CDEF);
    src_q.push_back(64'h0000_0F00_0000_1235);
    src_q.push_back(64'h0000_0000_0000_0FFE);
    go_pulse(3);
    wait_idle;
    stall_n = 0;
    chk("stall_hs", hs_cnt - h0, 3);
    chk("stall_done", done_cnt - d0, 1);

    // back-to-back samples
    c0_base = 50;
    c1_base = -700;
    d0 = done_cnt;
    h0 = hs_cnt;
    last_hs = -1;
    tp_chk = 1'b1;
    src_q.push_back(64'h7FFF_0000_1234_5678);
    src_q.push_back(64'h0004_0000_0000_00F1);
    src_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    src_q.push_back(64'h0000_0000_8000_7770);
    src_q.push_back(64'h0000_0000_0000_0009);
    go_pulse(5);
    wait_idle;
    tp_chk = 1'b0;
    chk("tp_hs", hs_cnt - h0, 5);
    chk("tp_done", done_cnt - d0, 1);

    // abort in LOOKUP of the second of four
    c0_base = 2000;
    c1_base = 3000;
    d0 = done_cnt;
    h0 = hs_cnt;
    src_q.push_back(64'h1000_0000_0001_2340);
    src_q.push_back(64'h0200_0000_0004_5670);
    src_q.push_back(64'h0030_0000_0000_1110);
    src_q.push_back(64'h0004_0000_0000_2220);
    t = cap_cnt + 2;
    go_pulse(4);
    wait_cap(t);
    tick;
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.awgn_valid, 0);
    chk("abort_rnd_ready", bus.rnd_ready, 0);
    repeat (6) begin
      tick;
      chk("abort_no_fetch", bus.rnd_ready, 0);
    end
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_hs", hs_cnt - h0, 1);
    src_q.delete();
    exp_q.delete();
    tick;

    // reset while in MAC
    c0_base = 1000;
    c1_base = 500;
    src_q.push_back(64'h0800_0000_0007_0000);
    src_q.push_back(64'h0080_0000_0001_0000);
    t = cap_cnt + 1;
    go_pulse(2);
    wait_cap(t);
    tick;
    tick;
    rst = 1'b1;
    tick;
    check_zero("mac_rst");
    rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    stall_ctr = 0;
    tick;

    // go with zero length is ignored
    d0 = done_cnt;
    go_pulse(0);
    chk("len0_busy", bus.busy, 0);
    tick;
    chk("len0_busy2", bus.busy, 0);
    chk("len0_done", done_cnt - d0, 0);

    // go and length change while busy are ignored
    c0_base = -50;
    c1_base = 4000;
    d0 = done_cnt;
    h0 = hs_cnt;
    src_q.push_back(64'h0000_2000_0000_4448);
    src_q.push_back(64'h4000_0000_0000_1001);
    go_pulse(2);
    tick;
    tick;
    go_pulse(9);
    wait_idle;
    chk("busy_go_hs", hs_cnt - h0, 2);
    chk("busy_go_done", done_cnt - d0, 1);

    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/awgn_burst_ctrl.md
AWGN_BURST_CTRL -- requirements
Module: awgn_burst_ctrl

Interface
REQ-001 SHALL have parameter RND_W, default 64, uniform random word width (>= MASK_W+4).
REQ-002 SHALL have parameter OUT_W, default 16, signed sample and coefficient width.
REQ-003 SHALL have parameter MASK_W, default 15, fractional width of interpolation operand.
REQ-004 SHALL have parameter SEG_W, default 7, segment/ROM address width.
REQ-005 SHALL have parameter CNT_W, default 8, burst length counter width.
REQ-006 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-007 SHALL have: clk  in  1  clock, rising edge.
REQ-008 SHALL have: rst  in  1  synchronous active-high reset.
REQ-009 SHALL have: go  in  1  start burst, sampled only in IDLE.
REQ-010 SHALL have: abort  in  1  cancel burst in any non-IDLE state.
REQ-011 SHALL have: burst_len  in  CNT_W  samples per burst, latched on accepted go.
REQ-012 SHALL have: rnd_valid  in  1  random word available.
REQ-013 SHALL have: rnd  in  RND_W  uniform random word.
REQ-014 SHALL have: rnd_ready  out  1  block accepts rnd this cycle.
REQ-015 SHALL have: rom_addr  out  SEG_W  coefficient table address (segment index).
REQ-016 SHALL have: rom_c0  in  OUT_W  signed offset coefficient, valid one cycle after rom_addr.
REQ-017 SHALL have: rom_c1  in  OUT_W  signed slope coefficient, valid one cycle after rom_addr.
REQ-018 SHALL have: awgn_valid  out  1  awgn_out holds a sample.
REQ-019 SHALL have: awgn_ready  in  1  downstream accepts sample.
REQ-020 SHALL have: awgn_out  out  OUT_W  signed Gaussian sample.
REQ-021 SHALL have: busy  out  1  high in every state except IDLE.
REQ-022 SHALL have: done  out  1  one-cycle pulse at normal burst completion.

Function
REQ-023 SHALL implement states IDLE, FETCH, LZD, LOOKUP, MAC, OUT, DONE.
REQ-024 IDLE: go=1 and burst_len!=0 -> FETCH, remaining<=burst_len; go with burst_len==0 ignored, no done.
REQ-025 FETCH: rnd_ready=1; on rnd_valid=1 capture rnd -> LZD; rnd_ready=0 in all other states.
REQ-026 LZD: seg = leading-zero count of rnd[RND_W-1:3], equal to RND_W-3 when that field is all zero; rom_addr<=seg[SEG_W-1:0] -> LOOKUP.
REQ-027 LOOKUP: rom_addr held; capture rom_c0, rom_c1 at end of cycle -> MAC.
REQ-028 MAC: x = rnd[MASK_W+2:3] unsigned; y = c0 + ((c1*x) arithmetic-shift-right MASK_W), full precision; -> OUT.
REQ-029 MAC: if rnd[0]=1, y=-y; result saturated to [-(2^(OUT_W-1)-1), 2^(OUT_W-1)-1] and registered into awgn_out.
REQ-030 rnd[2:1] SHALL be unused.
REQ-031 OUT: awgn_valid=1, awgn_out stable until awgn_ready=1; on handshake remaining decrements; remaining==1 -> DONE else FETCH.
REQ-032 DONE: done=1 for exactly one cycle -> IDLE; awgn_valid=0.
REQ-033 Latency: rnd capture edge to awgn_valid high = 3 cycles; steady throughput one sample per 5 cycles with zero stalls.
REQ-034 go while busy SHALL be ignored; burst_len changes while busy SHALL have no effect.
REQ-035 abort=1 in non-IDLE state -> IDLE next cycle, awgn_valid and rnd_ready drop, no done pulse; abort has priority over all transitions; abort in IDLE ignored.
REQ-036 awgn_out SHALL retain last sample after burst end until overwritten.

Reset
REQ-037 rst=1 SHALL force IDLE, remaining=0, rom_addr=0, awgn_out=0, awgn_valid=0, rnd_ready=0, busy=0, done=0 at next edge, overriding go and abort, including mid-burst.

Verification
REQ-038 burst_len=1, rnd=64'h8000_0000_0002_0000, c0=100, c1=200, awgn_ready=1 -> rom_addr=0, awgn_out=16'h00C8, then done pulse.
REQ-039 Same with rnd bit0=1 -> awgn_out=16'hFF38; rnd[63:3]=0 -> rom_addr=7'h3D.
REQ-040 c0=c1=32767, rnd[17:3]=15'h7FFF, sign 0 -> 16'h7FFF; sign 1 -> 16'h8001 (saturation).
REQ-041 burst_len=3, awgn_ready low 4 cycles at each OUT -> 3 handshakes, awgn_out stable while stalled, single done after third.
REQ-042 abort asserted in LOOKUP of sample 2 of 4 -> IDLE next cycle, no done, no further rnd_ready; rst mid-MAC -> all outputs 0.
REQ-043 go with burst_len=0 and go while busy -> no state change, no done.
